// File: rtl/watch_input_controller.sv
// Button front end for the multi-mode watch: synchronizes and debounces four buttons,
// arbitrates press events onto one-cycle command pulses, owns the mode register and
// generates the long-press stopwatch reset.
module watch_input_controller #(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int LONG_PRESS_CYCLES = 200
) (
    input  logic       m_clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [1:0] currentMode,
    output logic       set,
    output logic       clear,
    output logic       lap_save,
    output logic       sw_reset
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_CYCLES - 1);

    // Bit positions of each button in the per-button vectors.
    localparam int B_MODE  = 0;
    localparam int B_SET   = 1;
    localparam int B_CLEAR = 2;
    localparam int B_LAP   = 3;

    logic [3:0] btn_raw;
    logic [3:0] db_level;
    logic [3:0] press;

    assign btn_raw = {btn_lap, btn_clear, btn_set, btn_mode};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic             sync1_q, sync1_d;
            logic             s_q, s_d;
            logic             db_q, db_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                sync1_d = btn_raw[gi];
                s_d     = sync1_q;
                db_d    = db_q;
                cnt_d   = cnt_q;
                if (s_q == db_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    db_d  = s_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge m_clk or posedge reset) begin
                if (reset) begin
                    sync1_q <= 1'b0;
                    s_q     <= 1'b0;
                    db_q    <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= sync1_d;
                    s_q     <= s_d;
                    db_q    <= db_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign db_level[gi] = db_q;
            // Press is flagged on the same edge the debounced level rises.
            assign press[gi]    = db_d & ~db_q;
        end
    endgenerate

    logic [3:0]        pending_q, pending_d;
    logic [3:0]        grant;
    logic [1:0]        mode_q, mode_d;
    logic              set_q, set_d;
    logic              clear_q, clear_d;
    logic              lap_q, lap_d;
    logic              sw_reset_q, sw_reset_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    always_comb begin
        grant = '0;
        if (pending_q[B_MODE]) begin
            grant[B_MODE] = 1'b1;
        end else if (pending_q[B_CLEAR]) begin
            grant[B_CLEAR] = 1'b1;
        end else if (pending_q[B_SET]) begin
            grant[B_SET] = 1'b1;
        end else if (pending_q[B_LAP]) begin
            grant[B_LAP] = 1'b1;
        end

        pending_d = (pending_q & ~grant) | press;
        mode_d    = mode_q;
        if (grant[B_MODE]) begin
            mode_d = mode_q + 2'd1;
            // Commands queued behind a mode change belong to the old mode; drop them.
            pending_d[B_SET]   = 1'b0;
            pending_d[B_CLEAR] = 1'b0;
            pending_d[B_LAP]   = 1'b0;
        end

        set_d   = grant[B_SET];
        clear_d = grant[B_CLEAR];
        lap_d   = grant[B_LAP];

        hold_d = hold_q;
        if (!db_level[B_CLEAR]) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
        end

        // Saturation makes the fire condition reachable only once per press.
        sw_reset_d = db_level[B_CLEAR] && (hold_q == HOLD_FIRE) && (mode_q == 2'd2);
    end

    always_ff @(posedge m_clk or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            mode_q     <= 2'd0;
            set_q      <= 1'b0;
            clear_q    <= 1'b0;
            lap_q      <= 1'b0;
            sw_reset_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            pending_q  <= pending_d;
            mode_q     <= mode_d;
            set_q      <= set_d;
            clear_q    <= clear_d;
            lap_q      <= lap_d;
            sw_reset_q <= sw_reset_d;
            hold_q     <= hold_d;
        end
    end

    assign currentMode = mode_q;
    assign set         = set_q;
    assign clear       = clear_q;
    assign lap_save    = lap_q;
    assign sw_reset    = sw_reset_q;

endmodule

// File: tb/tb_watch_input_controller.sv
// Directed bench for watch_input_controller: counts output pulses and the cycle they
// appear in, and compares them against hand-derived edge numbers (D=4, L=200).
module tb_watch_input_controller;

    logic       m_clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_set, btn_clear, btn_lap;
    logic [1:0] currentMode;
    logic       set, clear, lap_save, sw_reset;

    always #5 m_clk = ~m_clk;

    watch_input_controller #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(200)
    ) dut (
        .m_clk      (m_clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_set    (btn_set),
        .btn_clear  (btn_clear),
        .btn_lap    (btn_lap),
        .currentMode(currentMode),
        .set        (set),
        .clear      (clear),
        .lap_save   (lap_save),
        .sw_reset   (sw_reset)
    );

    int cyc = 0;
    always @(posedge m_clk) cyc++;

    int n_set = 0, n_clear = 0, n_lap = 0, n_swr = 0, n_overlap = 0;
    int last_set = -1, last_clear = -1, last_lap = -1, last_swr = -1;

    // The value of cyc seen here is the index of the edge that registered the output.
    always @(negedge m_clk) begin
        if (set)      begin n_set++;   last_set   = cyc; end
        if (clear)    begin n_clear++; last_clear = cyc; end
        if (lap_save) begin n_lap++;   last_lap   = cyc; end
        if (sw_reset) begin n_swr++;   last_swr   = cyc; end
        if (int'(set) + int'(clear) + int'(lap_save) > 1) n_overlap++;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge m_clk);
            #1;
        end
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        tick(10);
        btn_mode = 1'b0;
        tick(10);
    endtask

    int c;
    int s0, s1, s2, s3, s4;
    int exp_modes [4] = '{2, 3, 0, 1};

    initial begin
        reset     = 1'b1;
        btn_mode  = 1'b1;
        btn_set   = 1'b1;
        btn_clear = 1'b1;
        btn_lap   = 1'b1;
        tick(4);
        check("reset_mode", int'(currentMode), 0);
        check("reset_set", int'(set), 0);
        check("reset_clear", int'(clear), 0);
        check("reset_lap", int'(lap_save), 0);
        check("reset_swr", int'(sw_reset), 0);

        // Release reset with only btn_set still held.
        btn_mode  = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
        s0 = n_set;
        c = cyc;
        reset = 1'b0;
        tick(20);
        check("held_set_count", n_set - s0, 1);
        check("held_set_edge", last_set, c + 7);
        check("held_set_mode", int'(currentMode), 0);
        btn_set = 1'b0;
        tick(10);

        // Bounce rejection on lap, both press and release.
        s0 = n_lap;
        for (int k = 0; k < 3; k++) begin
            btn_lap = 1'b1;
            tick(2);
            btn_lap = 1'b0;
            tick(2);
        end
        btn_lap = 1'b1;
        c = cyc;
        tick(15);
        check("bounce_lap_edge", last_lap, c + 7);
        btn_lap = 1'b0;
        tick(2);
        btn_lap = 1'b1;
        tick(15);
        btn_lap = 1'b0;
        tick(10);
        check("bounce_lap_count", n_lap - s0, 1);

        // Simultaneous clear/set/lap: priority clear > set > lap.
        s0 = n_clear; s1 = n_set; s2 = n_lap; s3 = n_overlap;
        btn_clear = 1'b1;
        btn_set   = 1'b1;
        btn_lap   = 1'b1;
        c = cyc;
        tick(12);
        check("simul_clear_edge", last_clear, c + 7);
        check("simul_set_edge", last_set, c + 8);
        check("simul_lap_edge", last_lap, c + 9);
        btn_clear = 1'b0;
        btn_set   = 1'b0;
        btn_lap   = 1'b0;
        tick(10);
        check("simul_clear_count", n_clear - s0, 1);
        check("simul_set_count", n_set - s1, 1);
        check("simul_lap_count", n_lap - s2, 1);
        check("simul_overlap", n_overlap - s3, 0);

        // Mode and set together: mode wins, set is discarded.
        s0 = n_set;
        btn_mode = 1'b1;
        btn_set  = 1'b1;
        c = cyc;
        tick(6);
        check("collide_mode_before", int'(currentMode), 0);
        tick(1);
        check("collide_mode_after", int'(currentMode), 1);
        tick(5);
        btn_mode = 1'b0;
        btn_set  = 1'b0;
        tick(10);
        check("collide_no_set", n_set - s0, 0);

        for (int k = 0; k < 4; k++) begin
            press_mode();
            check($sformatf("wrap_mode_%0d", k), int'(currentMode), exp_modes[k]);
        end

        // Long press of clear in mode 2.
        press_mode();
        check("lp_mode2", int'(currentMode), 2);
        s0 = n_clear; s4 = n_swr;
        btn_clear = 1'b1;
        c = cyc;
        tick(300);
        check("lp_clear_edge", last_clear, c + 7);
        check("lp_swr_edge", last_swr, c + 206);
        btn_clear = 1'b0;
        tick(10);
        check("lp_clear_count", n_clear - s0, 1);
        check("lp_swr_count", n_swr - s4, 1);

        // Same long press in mode 1: no stopwatch reset.
        press_mode();
        press_mode();
        press_mode();
        check("lp_mode1", int'(currentMode), 1);
        s0 = n_clear; s4 = n_swr;
        btn_clear = 1'b1;
        tick(300);
        btn_clear = 1'b0;
        tick(10);
        check("lp1_clear_count", n_clear - s0, 1);
        check("lp1_swr_count", n_swr - s4, 0);

        // Reset while set and lap are pending.
        s1 = n_set; s2 = n_lap;
        btn_set = 1'b1;
        btn_lap = 1'b1;
        tick(6);
        reset = 1'b1;
        #1;
        check("midq_mode", int'(currentMode), 0);
        check("midq_set", int'(set), 0);
        check("midq_lap", int'(lap_save), 0);
        btn_set = 1'b0;
        btn_lap = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(20);
        check("midq_set_count", n_set - s1, 0);
        check("midq_lap_count", n_lap - s2, 0);
        check("midq_mode_after", int'(currentMode), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
